test_status_monitor: RTL and testbench

//   Parametrised simulation/FPGA test harness for the risc_v_soc: replaces per-cycle register dumping

---
 rtl/test_status_monitor_pkg.sv | 19 +
 rtl/test_status_monitor_if.sv | 19 +
 rtl/test_status_monitor_sat_counter.sv | 17 +
 rtl/test_status_monitor.sv | 112 +++++++++++
 tb/tb_test_status_monitor.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/test_status_monitor_pkg.sv
// Shared encodings for the test status monitor: verdict states and the tohost pass value.
package test_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } mon_state_e;

    localparam int unsigned TOHOST_PASS_VAL = 1;

    function automatic logic is_terminal(mon_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
    endfunction

endpackage

// File: rtl/test_status_monitor_if.sv
// Snooped core activity: data-store bus and retire stream, observed by the monitor.
interface test_status_monitor_if #(
    parameter int XLEN = 32
);
    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_data;
    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;

    modport master (
        output st_valid, st_addr, st_be, st_data, ret_valid, ret_pc
    );

    modport slave (
        input st_valid, st_addr, st_be, st_data, ret_valid, ret_pc
    );
endinterface

// File: rtl/test_status_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end
endmodule

// File: rtl/test_status_monitor.sv
// Passive test-verdict monitor: decodes tohost stores, counts cycles/retires, detects timeout and
// self-loop hangs. Drives nothing back into the core.
//   state      | meaning
//   ST_IDLE    | waiting for en, counters held at 0
//   ST_RUN     | monitoring, counters advancing
//   ST_PASS    | tohost written with 1
//   ST_FAIL    | tohost written with odd value > 1
//   ST_TIMEOUT | cycle budget exhausted
//   ST_HANG    | same PC retired HANG_LIMIT times in a row
module test_status_monitor
    import test_mon_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int              TIMEOUT_CYC = 100000,
    parameter int              HANG_LIMIT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    test_status_monitor_if.slave       bus,
    output logic [2:0]                 state,
    output logic                       done,
    output logic                       pass,
    output logic [XLEN-2:0]            fail_test,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           instret_cnt
);
    localparam int HW = $clog2(HANG_LIMIT + 1);

    mon_state_e      st_q, st_d;
    logic [XLEN-2:0] fail_q, fail_d;
    logic [XLEN-1:0] last_pc_q;
    logic [HW-1:0]   rep_q, rep_nxt;
    logic            in_run, hit, hit_pass, hit_fail, at_timeout, hang_now;

    assign in_run = (st_q == ST_RUN);

    // Only full-word, word-aligned stores to tohost count as a report.
    assign hit = bus.st_valid && (bus.st_be == 4'hF) && (bus.st_addr[1:0] == 2'b00) &&
                 (bus.st_addr[XLEN-1:2] == TOHOST_ADDR[XLEN-1:2]);
    assign hit_pass   = hit && (bus.st_data == XLEN'(TOHOST_PASS_VAL));
    assign hit_fail   = hit && bus.st_data[0] && (bus.st_data != XLEN'(TOHOST_PASS_VAL));
    assign at_timeout = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    assign rep_nxt  = (bus.ret_pc == last_pc_q) ? rep_q + HW'(1) : HW'(1);
    assign hang_now = bus.ret_valid && (rep_nxt == HW'(HANG_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc_q <= '0;
            rep_q     <= '0;
        end else if (in_run && bus.ret_valid) begin
            last_pc_q <= bus.ret_pc;
            rep_q     <= rep_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            fail_q <= '0;
        end else begin
            st_q   <= st_d;
            fail_q <= fail_d;
        end
    end

    // Verdict priority: tohost report, then timeout, then hang.
    always_comb begin
        st_d   = st_q;
        fail_d = fail_q;
        case (st_q)
            ST_IDLE: begin
                if (en) st_d = ST_RUN;
            end
            ST_RUN: begin
                if (hit_pass) begin
                    st_d = ST_PASS;
                end else if (hit_fail) begin
                    st_d   = ST_FAIL;
                    fail_d = bus.st_data[XLEN-1:1];
                end else if (at_timeout) begin
                    st_d = ST_TIMEOUT;
                end else if (hang_now) begin
                    st_d = ST_HANG;
                end
            end
            default: ;
        endcase
    end

    assign state     = st_q;
    assign done      = is_terminal(st_q);
    assign pass      = (st_q == ST_PASS);
    assign fail_test = fail_q;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .inc (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk (clk),
        .rst (rst),
        .inc (in_run && bus.ret_valid),
        .q   (instret_cnt)
    );
endmodule

// File: tb/tb_test_status_monitor.sv
// Randomized bench for test_status_monitor against a queue-based verdict model, plus directed scenarios.
module tb_test_status_monitor;
    localparam int TMO = 50;
    localparam int HL  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [2:0]  state;
    logic        done, pass;
    logic [30:0] fail_test;
    logic [31:0] cycle_cnt, instret_cnt;

    test_status_monitor_if #(.XLEN(32)) bus ();

    test_status_monitor #(
        .XLEN        (32),
        .CNT_W       (32),
        .TOHOST_ADDR (32'h0000_1000),
        .TIMEOUT_CYC (TMO),
        .HANG_LIMIT  (HL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .bus         (bus),
        .state       (state),
        .done        (done),
        .pass        (pass),
        .fail_test   (fail_test),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;

    // Model: 0 idle, 1 run, 2 pass, 3 fail, 4 timeout, 5 hang.
    int          m_state = 0;
    longint      m_cyc = 0;
    longint      m_ret = 0;
    logic [30:0] m_fail = '0;
    logic [31:0] hist[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit hit, hung;
        int n;
        if (m_state == 0) begin
            if (en) m_state = 1;
        end else if (m_state == 1) begin
            if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (bus.ret_valid) begin
                if (m_ret < 64'hFFFF_FFFF) m_ret = m_ret + 1;
                hist.push_back(bus.ret_pc);
            end
            hit = bus.st_valid && (bus.st_be == 4'hF) && (bus.st_addr == 32'h0000_1000);
            if (hit && bus.st_data == 32'd1) begin
                m_state = 2;
            end else if (hit && bus.st_data[0]) begin
                m_state = 3;
                m_fail  = bus.st_data[31:1];
            end else if (m_cyc == TMO) begin
                m_state = 4;
            end else if (bus.ret_valid && hist.size() >= HL) begin
                n    = hist.size();
                hung = 1'b1;
                for (int k = 1; k < HL; k++)
                    if (hist[n-1-k] != hist[n-1]) hung = 1'b0;
                if (hung) m_state = 5;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_state = 0;
            m_cyc   = 0;
            m_ret   = 0;
            m_fail  = '0;
            hist.delete();
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("state",       64'(state),       64'(m_state));
            check("done",        64'(done),        64'(m_state >= 2));
            check("pass",        64'(pass),        64'(m_state == 2));
            check("fail_test",   64'(fail_test),   64'(m_fail));
            check("cycle_cnt",   64'(cycle_cnt),   64'(m_cyc));
            check("instret_cnt", 64'(instret_cnt), 64'(m_ret));
        end
    end

    task automatic drive(input bit e, input bit sv, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input bit rv, input logic [31:0] pc);
        en            = e;
        bus.st_valid  = sv;
        bus.st_addr   = a;
        bus.st_be     = be;
        bus.st_data   = d;
        bus.ret_valid = rv;
        bus.ret_pc    = pc;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        drive(1'b0, 1'b1, a, be, d, 1'b0, 32'h0);
    endtask

    task automatic retire(input logic [31:0] pc);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, pc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic start();
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    logic [31:0] pcs5[6] = '{32'h40, 32'h40, 32'h44, 32'h40, 32'h40, 32'h40};

    initial begin
        bit          e, sv, rv;
        logic [31:0] a, d, pc;
        logic [3:0]  be;
        int          r;

        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_be = '0; bus.st_data = '0;
        bus.ret_valid = 1'b0; bus.ret_pc = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_on = 1'b1;
        rst = 1'b0;
        check("reset_state", 64'(state), 64'd0);
        check("reset_cycle", 64'(cycle_cnt), 64'd0);
        idle(3);
        check("idle_no_en", 64'(state), 64'd0);

        // 1: ten distinct retires then tohost=1
        start();
        for (int i = 0; i < 10; i++) retire(32'h100 + 32'(4 * i));
        store(32'h1000, 4'hF, 32'h1);
        check("t1_pass",    64'(pass), 64'd1);
        check("t1_done",    64'(done), 64'd1);
        check("t1_instret", 64'(instret_cnt), 64'd10);
        check("t1_cycle",   64'(cycle_cnt), 64'd11);
        for (int i = 0; i < 3; i++) retire(32'h200);
        check("t1_frozen_ret", 64'(instret_cnt), 64'd10);
        check("t1_frozen_cyc", 64'(cycle_cnt), 64'd11);

        // 2: failing test number, sticky
        start();
        store(32'h1000, 4'hF, 32'h7);
        check("t2_state", 64'(state), 64'd3);
        check("t2_num",   64'(fail_test), 64'd3);
        store(32'h1000, 4'hF, 32'h1);
        check("t2_sticky", 64'(state), 64'd3);
        check("t2_num2",   64'(fail_test), 64'd3);

        // 3: partial, misaligned and even writes never give a verdict
        start();
        store(32'h1000, 4'h1, 32'h1);
        store(32'h1002, 4'hF, 32'h1);
        store(32'h1000, 4'hF, 32'h4);
        check("t3_run", 64'(state), 64'd1);

        // 4: timeout exactly at TMO, and pass wins on the same cycle
        start();
        idle(TMO - 1);
        check("t4_pre", 64'(state), 64'd1);
        idle(1);
        check("t4_tmo",   64'(state), 64'd4);
        check("t4_cycle", 64'(cycle_cnt), 64'(TMO));
        idle(3);
        check("t4_hold", 64'(cycle_cnt), 64'(TMO));
        start();
        idle(TMO - 1);
        store(32'h1000, 4'hF, 32'h1);
        check("t4_passwins", 64'(state), 64'd2);
        check("t4_cycle2",   64'(cycle_cnt), 64'(TMO));

        // 5: hang across stall gaps; broken run does not hang
        start();
        for (int i = 0; i < HL; i++) begin
            retire(32'h40);
            idle(1);
        end
        check("t5_hang", 64'(state), 64'd5);
        start();
        for (int i = 0; i < 6; i++) begin
            retire(pcs5[i]);
            idle(1);
        end
        check("t5_nohang", 64'(state), 64'd1);
        check("t5_instret", 64'(instret_cnt), 64'd6);

        // 6: reset mid-run
        start();
        idle(20);
        check("t6_cyc20", 64'(cycle_cnt), 64'd20);
        rst = 1'b1;
        #1;
        check("t6_idle", 64'(state), 64'd0);
        check("t6_zero", 64'(cycle_cnt), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        idle(1);
        check("t6_fresh", 64'(cycle_cnt), 64'd1);

        // Randomized episodes checked by the model every cycle
        for (int ep = 0; ep < 150; ep++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                e  = ($urandom_range(0, 9) != 0);
                sv = ($urandom_range(0, 7) == 0);
                r  = $urandom_range(0, 3);
                a  = (r < 2) ? 32'h1000 : (r == 2) ? 32'h1000 + 32'($urandom_range(1, 7)) : $urandom;
                be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                r  = $urandom_range(0, 7);
                d  = (r == 0) ? 32'h1 : (r == 1) ? $urandom : 32'($urandom_range(0, 15));
                rv = $urandom_range(0, 1);
                r  = $urandom_range(0, 9);
                pc = (r < 5) ? 32'h40 : (r < 7) ? 32'h44 : (r < 9) ? 32'h48 : $urandom;
                drive(e, sv, a, be, d, rv, pc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
